// File: rtl/l15_resp_model.sv
// l15_resp_model: cache-side responder standing in for the L1.5.
// Accepts core load/store requests, backs them with a local word-addressed
// SRAM and answers with LOAD_RET / ST_ACK after RESP_LAT extra wait cycles.
// Optional feature macro: L15_RESP_ERR_EN (unknown rqtype or out-of-range
// address answered with INT_RET, data 0, no SRAM write).
//
// state  | meaning
// S_IDLE | ready; request acked in the same cycle it is presented
// S_WAIT | request accepted, counting down the response latency
// S_RESP | response valid, held until the core acknowledges it
module l15_resp_model #(
  parameter int MEM_WORDS = 1024,
  parameter int RESP_LAT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  core_l15_rqtype,
  input  logic [2:0]  core_l15_size,
  input  logic [31:0] core_l15_address,
  input  logic [31:0] core_l15_data,
  input  logic        core_l15_val,
  output logic        l15_core_ack,
  output logic        l15_core_header_ack,
  output logic        l15_core_val,
  output logic [3:0]  l15_core_returntype,
  output logic [63:0] l15_core_data_0,
  output logic [63:0] l15_core_data_1,
  input  logic        core_l15_req_ack
);

  localparam int ADDR_W = $clog2(MEM_WORDS);

  localparam logic [3:0] RQ_LOAD  = 4'b0000;
  localparam logic [3:0] RQ_STORE = 4'b0001;
  localparam logic [3:0] RET_LOAD = 4'b0000;
  localparam logic [3:0] RET_ST   = 4'b0100;
  localparam logic [3:0] RET_INT  = 4'b0111;
  localparam logic [3:0] LAT      = 4'(RESP_LAT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              store_q, store_d;
  logic              err_q, err_d;
  logic [ADDR_W-3:0] line_q, line_d;
  logic              val_q, val_d;
  logic [3:0]        rtype_q, rtype_d;
  logic [63:0]       d0_q, d0_d;
  logic [63:0]       d1_q, d1_d;

  logic [31:0] mem [MEM_WORDS];

  logic              accept;
  logic [ADDR_W-1:0] req_widx;
  logic              req_store;
  logic              req_err;
  logic [3:0]        wr_be;
  logic [31:0]       wr_data;
  logic              wr_en;
  logic [ADDR_W-3:0] rd_line;
  logic              resp_store;
  logic              resp_err;
  logic [63:0]       line_d0;
  logic [63:0]       line_d1;
  logic              unused_addr;

  assign accept              = (state_q == S_IDLE) && core_l15_val && !rst;
  assign l15_core_ack        = accept;
  assign l15_core_header_ack = accept;

  assign req_widx  = core_l15_address[ADDR_W+1:2];
  assign req_store = (core_l15_rqtype == RQ_STORE);
  // Address bits above the SRAM are only inspected by the error check.
  assign unused_addr = ^core_l15_address[31:ADDR_W+2];

  // Classify requests the SRAM cannot serve.
  always_comb begin
`ifdef L15_RESP_ERR_EN
    req_err = ((core_l15_rqtype != RQ_LOAD) && (core_l15_rqtype != RQ_STORE)) ||
              (|core_l15_address[31:ADDR_W+2]);
`else
    req_err = 1'b0;
`endif
  end

  // Byte-lane steering; be[3] is lane 0 (bits [31:24], lowest byte address).
  always_comb begin
    wr_be   = 4'b0000;
    wr_data = core_l15_data;
    case (core_l15_size)
      3'b011: wr_be = 4'b1111;
      3'b010: begin
        wr_data = {2{core_l15_data[31:16]}};
        wr_be   = core_l15_address[1] ? 4'b0011 : 4'b1100;
      end
      3'b001: begin
        wr_data = {4{core_l15_data[31:24]}};
        wr_be   = 4'b1000 >> core_l15_address[1:0];
      end
      default: wr_be = 4'b0000;
    endcase
  end

  assign wr_en = accept && req_store && !req_err;

  // Stores commit on the accept edge so a following load sees them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[req_widx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // With zero latency the response is built straight from the live request.
  assign rd_line    = (state_q == S_IDLE) ? req_widx[ADDR_W-1:2] : line_q;
  assign resp_store = (state_q == S_IDLE) ? req_store : store_q;
  assign resp_err   = (state_q == S_IDLE) ? req_err   : err_q;
  assign line_d0    = {mem[{rd_line, 2'd0}], mem[{rd_line, 2'd1}]};
  assign line_d1    = {mem[{rd_line, 2'd2}], mem[{rd_line, 2'd3}]};

  // Next-state and response-register logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    store_d = store_q;
    err_d   = err_q;
    line_d  = line_q;
    val_d   = val_q;
    rtype_d = rtype_q;
    d0_d    = d0_q;
    d1_d    = d1_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          store_d = req_store;
          err_d   = req_err;
          line_d  = req_widx[ADDR_W-1:2];
          state_d = S_WAIT;
          cnt_d   = LAT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
      end
      S_RESP: begin
        if (core_l15_req_ack) begin
          state_d = S_IDLE;
          val_d   = 1'b0;
          rtype_d = 4'b0000;
          d0_d    = 64'd0;
          d1_d    = 64'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Capture the response when the latency has elapsed.
    if (((state_q == S_IDLE) && accept && (RESP_LAT == 0)) ||
        ((state_q == S_WAIT) && (cnt_q <= 4'd1))) begin
      state_d = S_RESP;
      val_d   = 1'b1;
      if (resp_err) begin
        rtype_d = RET_INT;
        d0_d    = 64'd0;
        d1_d    = 64'd0;
      end else if (resp_store) begin
        rtype_d = RET_ST;
        d0_d    = 64'd0;
        d1_d    = 64'd0;
      end else begin
        rtype_d = RET_LOAD;
        d0_d    = line_d0;
        d1_d    = line_d1;
      end
    end
  end

  // Control and response registers; reset drops any pending transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      store_q <= 1'b0;
      err_q   <= 1'b0;
      line_q  <= '0;
      val_q   <= 1'b0;
      rtype_q <= 4'd0;
      d0_q    <= 64'd0;
      d1_q    <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      store_q <= store_d;
      err_q   <= err_d;
      line_q  <= line_d;
      val_q   <= val_d;
      rtype_q <= rtype_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
    end
  end

  assign l15_core_val        = val_q;
  assign l15_core_returntype = rtype_q;
  assign l15_core_data_0     = d0_q;
  assign l15_core_data_1     = d1_q;

endmodule

// File: tb/tb_l15_resp_model.sv
// tb_l15_resp_model: randomized bench for l15_resp_model with a byte-array
// reference memory and an expected-response queue.
`timescale 1ns/1ps
module tb_l15_resp_model;

  localparam int MEM_WORDS = 1024;
  localparam int RESP_LAT  = 2;
  localparam int BYTES     = MEM_WORDS * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  core_l15_rqtype;
  logic [2:0]  core_l15_size;
  logic [31:0] core_l15_address;
  logic [31:0] core_l15_data;
  logic        core_l15_val;
  logic        l15_core_ack;
  logic        l15_core_header_ack;
  logic        l15_core_val;
  logic [3:0]  l15_core_returntype;
  logic [63:0] l15_core_data_0;
  logic [63:0] l15_core_data_1;
  logic        core_l15_req_ack;

  always #5 clk = ~clk;

  l15_resp_model #(.MEM_WORDS(MEM_WORDS), .RESP_LAT(RESP_LAT)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .core_l15_rqtype     (core_l15_rqtype),
    .core_l15_size       (core_l15_size),
    .core_l15_address    (core_l15_address),
    .core_l15_data       (core_l15_data),
    .core_l15_val        (core_l15_val),
    .l15_core_ack        (l15_core_ack),
    .l15_core_header_ack (l15_core_header_ack),
    .l15_core_val        (l15_core_val),
    .l15_core_returntype (l15_core_returntype),
    .l15_core_data_0     (l15_core_data_0),
    .l15_core_data_1     (l15_core_data_1),
    .core_l15_req_ack    (core_l15_req_ack)
  );

  typedef struct {
    logic [3:0]  rtype;
    logic [63:0] d0;
    logic [63:0] d1;
    int          acc_cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem_m [BYTES];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  bit         busy_m = 1'b0;
  bit         rst_prev = 1'b0;

  // Cycle count and the responder-busy window (accept to consume).
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_prev <= rst;
    if (rst) busy_m <= 1'b0;
    else if (l15_core_ack) busy_m <= 1'b1;
    else if (l15_core_val && core_l15_req_ack) busy_m <= 1'b0;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference behaviour: apply the request to the byte memory, return the response.
  function automatic exp_t model(input logic [3:0] rt, input logic [2:0] sz,
                                 input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   b;
    int   base;
    bit   err;
    b   = int'(a % BYTES);
    err = 1'b0;
`ifdef L15_RESP_ERR_EN
    err = ((rt != 4'd0) && (rt != 4'd1)) || (a >= BYTES);
`endif
    e.rtype   = 4'b0000;
    e.d0      = 64'd0;
    e.d1      = 64'd0;
    e.acc_cyc = cyc;
    if (err) begin
      e.rtype = 4'b0111;
    end else if (rt == 4'd1) begin
      e.rtype = 4'b0100;
      case (sz)
        3'd3: begin
          base = b - (b % 4);
          for (int i = 0; i < 4; i++) mem_m[base+i] = d[31-8*i -: 8];
        end
        3'd2: begin
          base = b - (b % 2);
          mem_m[base]   = d[31:24];
          mem_m[base+1] = d[23:16];
        end
        3'd1: mem_m[b] = d[31:24];
        default: ;
      endcase
    end else begin
      base = b - (b % 16);
      for (int i = 0; i < 8; i++) begin
        e.d0 = {e.d0[55:0], mem_m[base+i]};
        e.d1 = {e.d1[55:0], mem_m[base+8+i]};
      end
    end
    return e;
  endfunction

  task automatic issue(input logic [3:0] rt, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
    int n;
    core_l15_rqtype  = rt;
    core_l15_size    = sz;
    core_l15_address = a;
    core_l15_data    = d;
    core_l15_val     = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (l15_core_ack) break;
      n++;
      if (n > 200) begin
        n_cmp++;
        n_err++;
        $display("FAIL accept_timeout: no ack after %0d cycles, want ack", n);
        core_l15_val = 1'b0;
        return;
      end
    end
    exp_q.push_back(model(rt, sz, a, d));
    @(posedge clk);
    #1;
    core_l15_val     = 1'b0;
    core_l15_rqtype  = 4'($urandom);
    core_l15_address = $urandom;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    core_l15_val = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: checks handshake every cycle, pops and compares each new response.
  initial begin : mon
    exp_t        e;
    logic [3:0]  s_rt;
    logic [63:0] s_d0;
    logic [63:0] s_d1;
    bit          in_resp;
    bit          consumed;
    int          hold;
    in_resp  = 1'b0;
    consumed = 1'b0;
    hold     = 0;
    s_rt     = '0;
    s_d0     = '0;
    s_d1     = '0;
    core_l15_req_ack = 1'b0;
    forever begin
      @(negedge clk);
      chk("ack", {63'd0, l15_core_ack}, {63'd0, core_l15_val && !busy_m && !rst});
      chk("header_ack", {63'd0, l15_core_header_ack}, {63'd0, core_l15_val && !busy_m && !rst});
      if (rst_prev) begin
        chk("rst_val", {63'd0, l15_core_val}, 64'd0);
        chk("rst_rtype", {60'd0, l15_core_returntype}, 64'd0);
        chk("rst_d0", l15_core_data_0, 64'd0);
        chk("rst_d1", l15_core_data_1, 64'd0);
        in_resp  = 1'b0;
        consumed = 1'b0;
      end
      if (rst) begin
        core_l15_req_ack = 1'b0;
        in_resp  = 1'b0;
        consumed = 1'b0;
      end else if (consumed) begin
        chk("val_drop", {63'd0, l15_core_val}, 64'd0);
        consumed = 1'b0;
        core_l15_req_ack = 1'($urandom_range(0, 1));
      end else if (l15_core_val) begin
        if (!in_resp) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_resp: got rtype %h, want no response", l15_core_returntype);
          end else begin
            e = exp_q.pop_front();
            chk("latency", 64'(cyc - e.acc_cyc), 64'(1 + RESP_LAT));
            chk("rtype", {60'd0, l15_core_returntype}, {60'd0, e.rtype});
            chk("data_0", l15_core_data_0, e.d0);
            chk("data_1", l15_core_data_1, e.d1);
          end
          s_rt    = l15_core_returntype;
          s_d0    = l15_core_data_0;
          s_d1    = l15_core_data_1;
          in_resp = 1'b1;
          hold    = $urandom_range(0, 5);
        end else begin
          chk("hold_rtype", {60'd0, l15_core_returntype}, {60'd0, s_rt});
          chk("hold_d0", l15_core_data_0, s_d0);
          chk("hold_d1", l15_core_data_1, s_d1);
        end
        if (hold == 0) begin
          core_l15_req_ack = 1'b1;
          consumed = 1'b1;
          in_resp  = 1'b0;
        end else begin
          hold--;
          core_l15_req_ack = 1'b0;
        end
      end else begin
        core_l15_req_ack = 1'($urandom_range(0, 1));
      end
    end
  end

  // Stimulus.
  initial begin : drv
    logic [31:0] a;
    logic [3:0]  rt;
    int          r;
    int          n;
    core_l15_rqtype  = 4'd0;
    core_l15_size    = 3'd0;
    core_l15_address = 32'd0;
    core_l15_data    = 32'd0;
    core_l15_val     = 1'b1;
    rst              = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst          = 1'b0;
    core_l15_val = 1'b0;

    for (int w = 0; w < 256; w++) issue(4'd1, 3'd3, 32'(w * 4), $urandom);

    issue(4'd1, 3'd3, 32'h10, 32'h11223344);
    issue(4'd0, 3'd3, 32'h1C, 32'h0);
    issue(4'd1, 3'd1, 32'h13, 32'hAB000000);
    issue(4'd1, 3'd2, 32'h14, 32'hCDEF0000);
    issue(4'd0, 3'd3, 32'h10, 32'h0);
    issue(4'd5, 3'd3, 32'h20, 32'h0);

    issue(4'd0, 3'd3, 32'h40, 32'h0);
    do_reset();
    repeat (6) @(posedge clk);
    #1;
    issue(4'd1, 3'd3, 32'h44, 32'hDEADBEEF);
    do_reset();
    issue(4'd0, 3'd3, 32'h40, 32'h0);

    for (int k = 0; k < 400; k++) begin
      r  = $urandom_range(0, 9);
      rt = (r < 4) ? 4'd0 : (r < 8) ? 4'd1 : 4'($urandom_range(0, 15));
      a  = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) == 0) a[31:12] = 20'($urandom_range(1, 1048575));
      issue(rt, 3'($urandom_range(0, 7)), a, $urandom);
      r = $urandom_range(0, 2);
      if (r > 0) begin
        repeat (r) @(posedge clk);
        #1;
      end
    end

    n = 0;
    while ((exp_q.size() != 0 || busy_m) && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n >= 300) begin
      n_err++;
      $display("FAIL drain: %0d responses outstanding, want 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
